// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: pops one mole at a time in one of 9 holes,
// times each mole's lifetime and scores the player's button presses.
module mole_scheduler #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned MOLE_TICKS = 4,
  parameter int unsigned GAP_TICKS  = 1,
  parameter int unsigned GAME_MOLES = 30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RST_BTN,
  input  logic        start,
  input  logic [8:0]  btn_hit,
  output logic [8:0]  mole_mask,
  output logic [7:0]  score,
  output logic [7:0]  misses,
  output logic [7:0]  moles_left,
  output logic        game_over,
  output logic        busy,
  output logic [1:0]  dbg_state,
  output logic [15:0] dbg_lfsr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [7:0]    GAP_LAST   = 8'(GAP_TICKS - 1);
  localparam logic [7:0]    UP_LAST    = 8'(MOLE_TICKS - 1);
  localparam logic [7:0]    MOLES_INIT = 8'(GAME_MOLES);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tick_cnt_q, tick_cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [3:0]    prev_hole_q, prev_hole_d;
  logic [8:0]    mask_q, mask_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    misses_q, misses_d;
  logic [7:0]    left_q, left_d;
  logic          game_over_q, game_over_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          hit;
  logic          expire;
  logic [3:0]    r_nib;
  logic [3:0]    h_raw;
  logic [3:0]    h_pick;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

  always_comb begin
    tick    = (cnt_q == CNT_LAST);
    // In UP the mask holds exactly the active hole, so this is btn_hit[h].
    hit     = |(btn_hit & mask_q);
    expire  = tick && (tick_cnt_q == UP_LAST);
    r_nib   = lfsr_q[3:0];
    h_raw   = (r_nib >= 4'd9) ? (r_nib - 4'd9) : r_nib;
    h_pick  = h_raw;
    if (h_raw == prev_hole_q) begin
      h_pick = (h_raw == 4'd8) ? 4'd0 : h_raw + 4'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev_hole_d = prev_hole_q;
    mask_d      = mask_q;
    score_d     = score_q;
    misses_d    = misses_q;
    left_d      = left_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    cnt_d       = tick ? '0 : cnt_q + 1'b1;
    tick_cnt_d  = tick ? tick_cnt_q + 8'd1 : tick_cnt_q;

    unique case (state_q)
      IDLE, OVER: begin
        mask_d = '0;
        if (start) begin
          state_d  = GAP;
          score_d  = '0;
          misses_d = '0;
          left_d   = MOLES_INIT;
        end
      end
      GAP: begin
        mask_d = '0;
        if (tick && (tick_cnt_q == GAP_LAST)) begin
          state_d     = UP;
          prev_hole_d = h_pick;
          mask_d      = 9'd1 << h_pick;
        end
      end
      UP: begin
        if (hit || expire) begin
          // A hit on the expiry cycle still scores.
          if (hit) score_d  = sat_inc(score_q);
          else     misses_d = sat_inc(misses_q);
          mask_d  = '0;
          left_d  = sat_dec(left_q);
          state_d = (left_q <= 8'd1) ? OVER : GAP;
        end else if (btn_hit != 9'd0) begin
          misses_d = sat_inc(misses_q);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d      = '0;
      tick_cnt_d = '0;
    end

    game_over_d = (state_d == OVER);
    busy_d      = (state_d == GAP) || (state_d == UP);
  end

  always_ff @(posedge CLK) begin
    if (!RST_BTN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tick_cnt_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      prev_hole_q <= 4'd15;
      mask_q      <= '0;
      score_q     <= '0;
      misses_q    <= '0;
      left_q      <= '0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      lfsr_q      <= lfsr_d;
      prev_hole_q <= prev_hole_d;
      mask_q      <= mask_d;
      score_q     <= score_d;
      misses_q    <= misses_d;
      left_q      <= left_d;
      game_over_q <= game_over_d;
      busy_q      <= busy_d;
    end
  end

  assign mole_mask  = mask_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign moles_left = left_q;
  assign game_over  = game_over_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;
  assign dbg_lfsr   = lfsr_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler with a short tick so whole rounds
// fit in a few thousand cycles.
module tb_mole_scheduler;

  localparam int          TD   = 4;
  localparam int          MT   = 4;
  localparam int          GT   = 1;
  localparam int          GM   = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_UP   = 2'd2;
  localparam logic [1:0] S_OVER = 2'd3;

  logic        CLK = 1'b0;
  logic        RST_BTN = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  btn_hit = '0;
  logic [8:0]  mole_mask;
  logic [7:0]  score, misses, moles_left;
  logic        game_over, busy;
  logic [1:0]  dbg_state;
  logic [15:0] dbg_lfsr;

  mole_scheduler #(
    .TICK_DIV(TD), .MOLE_TICKS(MT), .GAP_TICKS(GT), .GAME_MOLES(GM), .LFSR_SEED(SEED)
  ) dut (
    .CLK(CLK), .RST_BTN(RST_BTN), .start(start), .btn_hit(btn_hit),
    .mole_mask(mole_mask), .score(score), .misses(misses), .moles_left(moles_left),
    .game_over(game_over), .busy(busy), .dbg_state(dbg_state), .dbg_lfsr(dbg_lfsr)
  );

  // ---------------- clock / reference LFSR ----------------
  always #5 CLK = ~CLK;

  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge CLK) begin
    m_lfsr_prev <= m_lfsr;
    m_lfsr <= !RST_BTN ? SEED
                       : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [23:0] exp_q[$];
  int          m_score, m_miss, m_left, m_prev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push();
    exp_q.push_back({8'(m_score), 8'(m_miss), 8'(m_left)});
  endtask

  task automatic sb_pop(input string tag);
    check_eq({tag, "_depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) check_eq(tag, {8'd0, score, misses, moles_left}, {8'd0, exp_q.pop_front()});
  endtask

  function automatic int pick(input logic [15:0] l, input int prev);
    int r, h;
    r = int'(l[3:0]);
    h = (r >= 9) ? r - 9 : r;
    if (h == prev) h = (h == 8) ? 0 : h + 1;
    return h;
  endfunction

  // ---------------- driver tasks (called on a negedge) ----------------
  task automatic do_start();
    start = 1'b1;
    m_score = 0; m_miss = 0; m_left = GM;
    sb_push();
    @(negedge CLK);
    start = 1'b0;
    sb_pop("start_counts");
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_game_over", 32'(game_over), 32'd0);
  endtask

  task automatic wait_mole(output int h);
    int c;
    c = 0;
    while (mole_mask == 9'd0 && c < 50) begin
      @(negedge CLK);
      c++;
    end
    check_eq("gap_len", 32'(c), 32'd4);
    h = pick(m_lfsr_prev, m_prev);
    m_prev = h;
    check_eq("mole_mask", 32'(mole_mask), 32'd1 << h);
    check_eq("up_state", 32'(dbg_state), 32'(S_UP));
  endtask

  task automatic press(input logic [8:0] bits, input int h, input bit up);
    btn_hit = bits;
    if (up && bits[h]) begin
      m_score++;
      m_left--;
    end else if (up && bits != 9'd0) begin
      m_miss++;
    end
    sb_push();
    @(negedge CLK);
    btn_hit = '0;
    sb_pop("press_counts");
  endtask

  // ---------------- main sequence ----------------
  int         h, c, last_h, repeats, obs_h;
  logic [8:0] seen;

  initial begin
    m_prev = 15;
    // T1: reset
    repeat (3) @(negedge CLK);
    check_eq("rst_lfsr", 32'(dbg_lfsr), 32'(SEED));
    RST_BTN = 1'b1;
    @(negedge CLK);
    check_eq("rst_outputs", {mole_mask, score, misses, moles_left, game_over, busy}, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check_eq("lfsr_run", 32'(dbg_lfsr), 32'(m_lfsr));

    // T2: start, first mole, hit
    do_start();
    wait_mole(h);
    press(9'd1 << h, h, 1'b1);
    check_eq("hit_mask", 32'(mole_mask), 32'd0);
    check_eq("hit_state", 32'(dbg_state), 32'(S_GAP));

    // T3: mole expires untouched
    wait_mole(h);
    m_miss++; m_left--;
    sb_push();
    c = 0;
    while (mole_mask != 9'd0 && c < 40) begin
      @(negedge CLK);
      c++;
    end
    check_eq("expire_len", 32'(c), 32'd16);
    sb_pop("expire_counts");

    // T4: wrong presses then an all-bits press on the last mole
    wait_mole(h);
    press(9'h1FF ^ (9'd1 << h), h, 1'b1);
    check_eq("wrong_mask", 32'(mole_mask), 32'd1 << h);
    press(9'h1FF, h, 1'b1);
    check_eq("over_flag", 32'(game_over), 32'd1);
    check_eq("over_mask", 32'(mole_mask), 32'd0);
    check_eq("over_busy", 32'(busy), 32'd0);
    press(9'h1FF, h, 1'b0);
    check_eq("over_hold", 32'(game_over), 32'd1);

    // T5: restart, hit on the exact expiry cycle
    do_start();
    wait_mole(h);
    repeat (15) @(negedge CLK);
    press(9'd1 << h, h, 1'b1);
    check_eq("edge_hit_mask", 32'(mole_mask), 32'd0);
    wait_mole(h);
    press(9'd1 << h, h, 1'b1);
    wait_mole(h);
    press(9'd1 << h, h, 1'b1);
    check_eq("round2_over", 32'(game_over), 32'd1);

    // T6: reset while a mole is up
    do_start();
    wait_mole(h);
    press(9'd1 << h, h, 1'b1);
    wait_mole(h);
    RST_BTN = 1'b0;
    @(negedge CLK);
    RST_BTN = 1'b1;
    m_prev = 15;
    check_eq("abort_outputs", {mole_mask, score, misses, moles_left, game_over, busy}, 32'd0);
    check_eq("abort_state", 32'(dbg_state), 32'(S_IDLE));

    // Long run of picks
    repeats = 0;
    seen    = '0;
    last_h  = -1;
    for (int i = 0; i < 1000; i++) begin
      if (dbg_state == S_IDLE || dbg_state == S_OVER) do_start();
      wait_mole(h);
      obs_h = -1;
      for (int b = 0; b < 9; b++) if (mole_mask[b]) obs_h = b;
      if (obs_h == last_h) repeats++;
      last_h = obs_h;
      seen |= mole_mask;
      press(9'd1 << h, h, 1'b1);
    end
    check_eq("no_repeat", 32'(repeats), 32'd0);
    check_eq("all_holes", 32'(seen), 32'h1FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
